npower_soc32: RTL and testbench
===============================

NPOWER_SOC32 -- requirements
Module: npower_soc32

Interface
REQ-001 SHALL have parameter PRESCALE, default 100000000, xclk cycles per heartbeat tick (min 2).
REQ-002 SHALL have port xclk, input, 1, sole clock; all flops on rising edge.
REQ-003 SHALL have port cpu_resetn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port sw, input, 8, board switches, asynchronous to xclk.
REQ-005 SHALL have port led, output, 8, board LEDs.
REQ-006 SHALL have ports TMDS_OUT_clk_p and TMDS_OUT_clk_n, output, 1 each, HDMI clock lane pair.
REQ-007 SHALL have ports TMDS_OUT_data_p and TMDS_OUT_data_n, output, 3 each, HDMI data lane pairs.
REQ-008 SHALL have DDR3 ports, all outputs except as noted:
- ddr3_ck_p, ddr3_ck_n, ddr3_cke, ddr3_reset_n, ddr3_ras_n, ddr3_cas_n, ddr3_we_n: 1 bit each.
- ddr3_ba: 3 bits; ddr3_addr: 15 bits; ddr3_dm: 2 bits; ddr3_odt: 1 bit.
- ddr3_dq: inout, 16 bits; ddr3_dqs_p and ddr3_dqs_n: inout, 2 bits each.

Function
REQ-009 SHALL derive internal reset rst_i from cpu_resetn: assert asynchronously, deassert through a 2-flop synchronizer; logic runs from the 3rd xclk rising edge after cpu_resetn rises.
REQ-010 SHALL pass sw through a 2-flop synchronizer to give sw_s.
REQ-011 SHALL implement prescaler cnt with range 0..PRESCALE-1; tick is asserted when cnt==PRESCALE-1, and cnt wraps to 0 on the same edge.
REQ-012 SHALL toggle led[7] (heartbeat) on every tick.
REQ-013 SHALL increment a 7-bit counter sec on every tick, wrapping from 127 to 0.
REQ-014 SHALL drive led[6:0]:
- sw_s[0]=1: led[6:0] = sw_s[7:1].
- sw_s[0]=0: led[6:0] = sec.
REQ-015 SHALL define the TMDS idle token as 10'b1101010100 (control token for C0=C1=0), sent LSB first.
REQ-016 SHALL use a lane bit index idx with range 0..9, advancing every cycle and wrapping from 9 to 0.
REQ-017 SHALL drive each cycle, from registers: TMDS_OUT_data_p[2:0] <= {3{token[idx]}} and TMDS_OUT_clk_p <= (idx<5).
REQ-018 SHALL drive every _n output as the exact complement of its _p output at all times.
REQ-019 SHALL park the DDR3 interface (no memory controller in this block):
- ddr3_reset_n=0, ddr3_cke=0, ddr3_ras_n=ddr3_cas_n=ddr3_we_n=1.
- ddr3_ba=0, ddr3_addr=0, ddr3_dm=0, ddr3_odt=0.
- ddr3_ck_p=0, ddr3_ck_n=1.
- ddr3_dq, ddr3_dqs_p, ddr3_dqs_n released to high-Z.
REQ-020 SHALL hold the DDR3 park values constant regardless of reset state.

Reset
REQ-021 SHALL, while rst_i is asserted, hold: cnt=0, sec=0, led[7]=0, idx=0, sw_s=0.
REQ-022 SHALL, while rst_i is asserted, hold TMDS_OUT_data_p=3'b000 and TMDS_OUT_clk_p=0.
REQ-023 SHALL, on reset assertion mid-operation, return all of the above to their reset values immediately, without waiting for a clock edge.

Structure
REQ-024 SHALL place in shared package npower_soc_pkg: the TMDS idle token constant, the TMDS lane count (3) and the PRESCALE default.
REQ-025 SHALL implement the reset synchronizer as sub-module soc_reset_sync; all other logic SHALL be inline.

Verification
REQ-026 Reset check: hold cpu_resetn=0 -> led=0x00, data_p=000, data_n=111, clk_p=0, ddr3_reset_n=0, ddr3_cke=0, dq=Z.
REQ-027 TMDS sequence: PRESCALE=4, release reset -> from the 3rd edge, data_p[0] repeats 0,0,1,0,1,0,1,0,1,1 and clk_p repeats 1,1,1,1,1,0,0,0,0,0.
REQ-028 Heartbeat: PRESCALE=4, sw=0 -> led[7] toggles every 4 cycles; led[6:0] reads 1,2,3 after ticks 1,2,3.
REQ-029 Wrap: PRESCALE=2, run 128 ticks -> led[6:0] returns to 0 and led[7]=0.
REQ-030 Switch mux: sw=8'hA5 -> led[6:0]=7'h52 within 3 cycles; then sw=8'hA4 -> led[6:0]=sec.
REQ-031 Reset mid-operation: pull cpu_resetn low at idx=6 -> outputs return to reset values immediately; after release the TMDS sequence restarts at bit 0.

Source files
------------

// File: rtl/npower_soc_pkg.sv
// Shared constants for the npower_soc32 board top: TMDS idle token, lane count, prescale default.
package npower_soc_pkg;

  localparam int unsigned TMDS_LANES       = 3;
  localparam int unsigned TMDS_BITS        = 10;
  localparam int unsigned PRESCALE_DEFAULT = 100000000;

  // Control token for C0=C1=0, shifted out LSB first
  localparam logic [TMDS_BITS-1:0] TMDS_IDLE = 10'b1101010100;

endpackage

// File: rtl/npower_soc32_if.sv
// DDR3 command/address pin bundle; the block only ever parks these pins.
interface npower_soc32_if;

  logic        ddr3_ck_p;
  logic        ddr3_ck_n;
  logic        ddr3_cke;
  logic        ddr3_reset_n;
  logic        ddr3_ras_n;
  logic        ddr3_cas_n;
  logic        ddr3_we_n;
  logic [2:0]  ddr3_ba;
  logic [14:0] ddr3_addr;
  logic [1:0]  ddr3_dm;
  logic        ddr3_odt;

  modport master (
    output ddr3_ck_p, ddr3_ck_n, ddr3_cke, ddr3_reset_n, ddr3_ras_n, ddr3_cas_n,
           ddr3_we_n, ddr3_ba, ddr3_addr, ddr3_dm, ddr3_odt
  );

  modport slave (
    input  ddr3_ck_p, ddr3_ck_n, ddr3_cke, ddr3_reset_n, ddr3_ras_n, ddr3_cas_n,
           ddr3_we_n, ddr3_ba, ddr3_addr, ddr3_dm, ddr3_odt
  );

endinterface

// File: rtl/npower_soc32_reset_sync.sv
// Reset synchronizer: asserts asynchronously, releases after two clk rising edges.
module soc_reset_sync (
  input  logic clk,
  input  logic rst_n,
  output logic rst_sync_n
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], 1'b1};
  end

  assign rst_sync_n = sync_q[1];

endmodule

// File: rtl/npower_soc32.sv
// Board top: heartbeat/seconds LEDs with switch override, idle TMDS lanes, parked DDR3.
module npower_soc32
  import npower_soc_pkg::*;
#(
  parameter int unsigned PRESCALE = PRESCALE_DEFAULT
) (
  input  logic                  xclk,
  input  logic                  cpu_resetn,
  input  logic [7:0]            sw,
  output logic [7:0]            led,
  output logic                  TMDS_OUT_clk_p,
  output logic                  TMDS_OUT_clk_n,
  output logic [TMDS_LANES-1:0] TMDS_OUT_data_p,
  output logic [TMDS_LANES-1:0] TMDS_OUT_data_n,
  npower_soc32_if.master        ddr3,
  inout  wire  [15:0]           ddr3_dq,
  inout  wire  [1:0]            ddr3_dqs_p,
  inout  wire  [1:0]            ddr3_dqs_n
);

  localparam int unsigned CNT_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IDX_W = 4;

  logic             rst_i_n;
  logic [7:0]       sw_m;
  logic [7:0]       sw_s;
  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic [6:0]       sec;
  logic [6:0]       sec_next;
  logic [IDX_W-1:0] idx;

  soc_reset_sync u_reset_sync (
    .clk        (xclk),
    .rst_n      (cpu_resetn),
    .rst_sync_n (rst_i_n)
  );

  // Switch synchronizer
  always_ff @(posedge xclk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      sw_m <= '0;
      sw_s <= '0;
    end else begin
      sw_m <= sw;
      sw_s <= sw_m;
    end
  end

  assign tick     = (cnt == CNT_W'(PRESCALE - 1));
  assign sec_next = tick ? sec + 7'd1 : sec;

  // Prescaler, seconds counter and LED register; led[7] is the heartbeat itself
  always_ff @(posedge xclk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      cnt <= '0;
      sec <= '0;
      led <= '0;
    end else begin
      cnt      <= tick ? '0 : cnt + CNT_W'(1);
      sec      <= sec_next;
      led[7]   <= led[7] ^ tick;
      led[6:0] <= sw_s[0] ? sw_s[7:1] : sec_next;
    end
  end

  // TMDS idle serializer: all lanes carry the same token bit, clock high for bits 0..4
  always_ff @(posedge xclk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      idx             <= '0;
      TMDS_OUT_data_p <= '0;
      TMDS_OUT_clk_p  <= 1'b0;
    end else begin
      idx             <= (idx == IDX_W'(TMDS_BITS - 1)) ? '0 : idx + IDX_W'(1);
      TMDS_OUT_data_p <= {TMDS_LANES{TMDS_IDLE[idx]}};
      TMDS_OUT_clk_p  <= (idx < IDX_W'(5));
    end
  end

  assign TMDS_OUT_data_n = ~TMDS_OUT_data_p;
  assign TMDS_OUT_clk_n  = ~TMDS_OUT_clk_p;

  // DDR3 parked: memory held in reset, bus released
  assign ddr3.ddr3_reset_n = 1'b0;
  assign ddr3.ddr3_cke     = 1'b0;
  assign ddr3.ddr3_ras_n   = 1'b1;
  assign ddr3.ddr3_cas_n   = 1'b1;
  assign ddr3.ddr3_we_n    = 1'b1;
  assign ddr3.ddr3_ba      = '0;
  assign ddr3.ddr3_addr    = '0;
  assign ddr3.ddr3_dm      = '0;
  assign ddr3.ddr3_odt     = 1'b0;
  assign ddr3.ddr3_ck_p    = 1'b0;
  assign ddr3.ddr3_ck_n    = 1'b1;

  assign ddr3_dq    = 'z;
  assign ddr3_dqs_p = 'z;
  assign ddr3_dqs_n = 'z;

endmodule

// File: tb/tb_npower_soc32.sv
// Self-checking bench: two tops (PRESCALE 4 and 2) against an arithmetic reference model.
module tb_npower_soc32;

  logic       xclk;
  logic       cpu_resetn;
  logic [7:0] sw;

  logic [7:0] led4, led2;
  logic       ck4p, ck4n, ck2p, ck2n;
  logic [2:0] d4p, d4n, d2p, d2n;
  wire [15:0] dq4, dq2;
  wire [1:0]  dqsp4, dqsn4, dqsp2, dqsn2;

  npower_soc32_if bus4 ();
  npower_soc32_if bus2 ();

  npower_soc32 #(.PRESCALE(4)) dut4 (
    .xclk(xclk), .cpu_resetn(cpu_resetn), .sw(sw), .led(led4),
    .TMDS_OUT_clk_p(ck4p), .TMDS_OUT_clk_n(ck4n),
    .TMDS_OUT_data_p(d4p), .TMDS_OUT_data_n(d4n),
    .ddr3(bus4), .ddr3_dq(dq4), .ddr3_dqs_p(dqsp4), .ddr3_dqs_n(dqsn4)
  );

  npower_soc32 #(.PRESCALE(2)) dut2 (
    .xclk(xclk), .cpu_resetn(cpu_resetn), .sw(sw), .led(led2),
    .TMDS_OUT_clk_p(ck2p), .TMDS_OUT_clk_n(ck2n),
    .TMDS_OUT_data_p(d2p), .TMDS_OUT_data_n(d2n),
    .ddr3(bus2), .ddr3_dq(dq2), .ddr3_dqs_p(dqsp2), .ddr3_dqs_n(dqsn2)
  );

  initial begin
    xclk = 1'b0;
    forever #5 xclk = ~xclk;
  end

  int         n_cmp;
  int         n_bad;
  int         e;
  logic [7:0] sw_model;
  int         seq_d [10] = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 1};

  // Active edges: logic starts on the 3rd rising edge after release
  function automatic int act();
    return (e > 2) ? e - 2 : 0;
  endfunction

  function automatic logic [7:0] exp_led(input int p);
    int ticks;
    logic [6:0] lo;
    ticks = act() / p;
    lo    = sw_model[0] ? sw_model[7:1] : 7'(ticks % 128);
    return {1'(ticks % 2), lo};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, e);
    end
  endtask

  task automatic step();
    @(posedge xclk);
    e++;
    @(negedge xclk);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_led4"}, 32'(led4), 32'h00);
    chk({tag, "_led2"}, 32'(led2), 32'h00);
    chk({tag, "_tmds4"}, 32'({d4p, d4n, ck4p, ck4n}), 32'(8'b000_111_0_1));
    chk({tag, "_tmds2"}, 32'({d2p, d2n, ck2p, ck2n}), 32'(8'b000_111_0_1));
    chk({tag, "_ddr_ctl"}, 32'({bus4.ddr3_reset_n, bus4.ddr3_cke, bus4.ddr3_ras_n,
                                bus4.ddr3_cas_n, bus4.ddr3_we_n, bus4.ddr3_ck_p,
                                bus4.ddr3_ck_n, bus4.ddr3_odt}), 32'(8'b0_0_1_1_1_0_1_0));
    chk({tag, "_ddr_addr"}, 32'({bus4.ddr3_ba, bus4.ddr3_addr, bus4.ddr3_dm}), 32'h0);
  endtask

  task automatic check_tmds();
    int   n;
    logic bd;
    logic bc;
    n  = act();
    bd = (n == 0) ? 1'b0 : 1'(seq_d[(n - 1) % 10]);
    bc = (n == 0) ? 1'b0 : (((n - 1) % 10) < 5);
    chk("tmds4", 32'({d4p, d4n, ck4p, ck4n}), 32'({{3{bd}}, {3{~bd}}, bc, ~bc}));
    chk("tmds2", 32'({d2p, d2n, ck2p, ck2n}), 32'({{3{bd}}, {3{~bd}}, bc, ~bc}));
  endtask

  task automatic check_led();
    chk("led4", 32'(led4), 32'(exp_led(4)));
    chk("led2", 32'(led2), 32'(exp_led(2)));
  endtask

  // Change switches, allow two synchronizer edges, then check each following cycle
  task automatic apply_sw(input logic [7:0] v, input int hold);
    sw = v;
    repeat (2) begin
      step();
      check_tmds();
    end
    sw_model = v;
    repeat (hold) begin
      step();
      check_tmds();
      check_led();
    end
  endtask

  task automatic release_and_run(input string tag, input int cycles);
    sw         = 8'h00;
    sw_model   = 8'h00;
    cpu_resetn = 1'b1;
    e          = 0;
    repeat (2) begin
      step();
      check_reset({tag, "_sync"});
    end
    repeat (cycles) begin
      step();
      check_tmds();
      check_led();
    end
  endtask

  task automatic mid_reset(input string tag);
    #2 cpu_resetn = 1'b0;
    #1 check_reset({tag, "_async"});
    sw = 8'($urandom);
    repeat (2) @(negedge xclk);
    check_reset({tag, "_held"});
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    e          = 0;
    sw_model   = 8'h00;
    cpu_resetn = 1'b0;
    sw         = 8'($urandom);

    repeat (3) @(negedge xclk);
    check_reset("por");

    release_and_run("rel", 40);

    apply_sw(8'hA5, 4);
    chk("swmux_a5", 32'(led4[6:0]), 32'h52);
    apply_sw(8'hA4, 4);

    for (int i = 0; i < 8; i++) begin
      apply_sw(8'($urandom), int'($urandom_range(1, 6)));
    end
    apply_sw(8'h00, 1);

    while (act() < 254) begin
      step();
      check_tmds();
    end
    chk("prewrap2", 32'(led2), 32'hFF);
    step();
    step();
    chk("wrap2", 32'(led2), 32'h00);
    check_led();

    while (act() % 10 != 6) begin
      step();
      check_tmds();
    end
    mid_reset("mid6");
    release_and_run("rel6", 15);

    repeat (int'($urandom_range(3, 25))) step();
    mid_reset("midr");
    release_and_run("relr", 25);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
